// File: rtl/core_net_rx_pkg.sv
// Shared network packet types and core-side constants for the net receive path.
// Holds the packet layout, op codes and the HALT/RUN state encoding.
package core_net_rx_pkg;

    localparam int mask_length_gp = 3;
    localparam int rs_imm_size_gp = 6;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [9:0]  id;
        net_op_e     net_op;
        logic [9:0]  net_addr;
        logic [31:0] net_data;
    } net_packet_s;

    typedef enum logic {
        RX_HALT = 1'b0,
        RX_RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/core_net_rx_rf_skid.sv
// One-entry holding buffer for net-side register file writes.
// Holds a write until the RF port is granted and drops REG packets that arrive while it is blocked.
module net_rf_skid #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_grant,
    output logic          o_wen,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_drop,
    output logic [15:0]   o_dropCnt
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_drop;
    logic [15:0]   r_dropCnt;
    logic          w_free;

    // The slot is reusable in the same cycle it is granted, so a new REG writes through with no bubble.
    assign w_free = !r_valid || i_grant;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_drop    <= 1'b0;
            r_dropCnt <= '0;
        end else begin
            if (i_push && w_free) begin
                r_valid <= 1'b1;
                r_addr  <= i_addr;
                r_data  <= i_data;
            end else if (r_valid && i_grant) begin
                r_valid <= 1'b0;
            end
            r_drop <= i_push && !w_free;
            if (i_push && !w_free && (r_dropCnt != 16'hFFFF)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
        end
    end

    assign o_wen     = r_valid;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_drop    = r_drop;
    assign o_dropCnt = r_dropCnt;

endmodule

// File: rtl/core_net_rx.sv
// Network-side responder for a core: filters packets by ID and drives imem fill, RF preload,
// PC load and barrier registers, and owns the core HALT/RUN state.
module core_net_rx
    import core_net_rx_pkg::*;
#(
    parameter logic [9:0] net_ID_p          = 10'd1,
    parameter int         imem_addr_width_p = 10,
    parameter int         rf_addr_width_p   = rs_imm_size_gp,
    parameter int         mask_length_p     = mask_length_gp
) (
    input  logic                         clk,
    input  logic                         reset,
    input  net_packet_s                  net_packet_i,
    output logic                         imem_wen_o,
    output logic [imem_addr_width_p-1:0] imem_addr_o,
    output logic [15:0]                  imem_data_o,
    output logic                         rf_wen_o,
    output logic [rf_addr_width_p-1:0]   rf_addr_o,
    output logic [31:0]                  rf_data_o,
    input  logic                         rf_grant_i,
    output logic                         pc_wen_o,
    output logic [imem_addr_width_p-1:0] pc_o,
    output logic [mask_length_p-1:0]     barrier_mask_o,
    output logic [mask_length_p-1:0]     barrier_bits_o,
    output logic                         run_o,
    output logic                         drop_o,
    output logic [15:0]                  drop_cnt_o
);

    logic w_accept;
    logic w_isInstr;
    logic w_isReg;
    logic w_isPc;
    logic w_isBar;

    rx_state_e                    r_state;
    logic                         r_run;
    logic                         r_imemWen;
    logic [imem_addr_width_p-1:0] r_imemAddr;
    logic [15:0]                  r_imemData;
    logic                         r_pcWen;
    logic [imem_addr_width_p-1:0] r_pc;
    logic [mask_length_p-1:0]     r_barrierMask;
    logic [mask_length_p-1:0]     r_barrierBits;

    assign w_accept  = (net_packet_i.id == net_ID_p) && (net_packet_i.net_op != NULL);
    assign w_isInstr = w_accept && (net_packet_i.net_op == INSTR);
    assign w_isReg   = w_accept && (net_packet_i.net_op == REG);
    assign w_isPc    = w_accept && (net_packet_i.net_op == PC);
    assign w_isBar   = w_accept && (net_packet_i.net_op == BAR);

    // A PC packet is the only way out of HALT; once running, only reset stops the core.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RX_HALT;
            r_run         <= 1'b0;
            r_imemWen     <= 1'b0;
            r_imemAddr    <= '0;
            r_imemData    <= '0;
            r_pcWen       <= 1'b0;
            r_pc          <= '0;
            r_barrierMask <= '0;
            r_barrierBits <= '0;
        end else begin
            r_imemWen <= w_isInstr;
            r_pcWen   <= w_isPc;
            if (w_isInstr) begin
                r_imemAddr <= net_packet_i.net_addr[imem_addr_width_p-1:0];
                r_imemData <= net_packet_i.net_data[15:0];
            end
            if (w_isPc) begin
                r_pc          <= net_packet_i.net_addr[imem_addr_width_p-1:0];
                r_barrierBits <= net_packet_i.net_data[mask_length_p-1:0];
            end
            if (w_isBar) begin
                r_barrierMask <= net_packet_i.net_data[mask_length_p-1:0];
            end
            case (r_state)
                RX_HALT: begin
                    if (w_isPc) begin
                        r_state <= RX_RUN;
                        r_run   <= 1'b1;
                    end
                end
                RX_RUN: begin
                    r_run <= 1'b1;
                end
                default: begin
                    r_state <= RX_HALT;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

    net_rf_skid #(
        .AW(rf_addr_width_p),
        .DW(32)
    ) u_rfSkid (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_isReg),
        .i_addr   (net_packet_i.net_addr[rf_addr_width_p-1:0]),
        .i_data   (net_packet_i.net_data),
        .i_grant  (rf_grant_i),
        .o_wen    (rf_wen_o),
        .o_addr   (rf_addr_o),
        .o_data   (rf_data_o),
        .o_drop   (drop_o),
        .o_dropCnt(drop_cnt_o)
    );

    assign imem_wen_o     = r_imemWen;
    assign imem_addr_o    = r_imemAddr;
    assign imem_data_o    = r_imemData;
    assign pc_wen_o       = r_pcWen;
    assign pc_o           = r_pc;
    assign barrier_mask_o = r_barrierMask;
    assign barrier_bits_o = r_barrierBits;
    assign run_o          = r_run;

endmodule
